// File: rtl/iob_wishbone2iob_pkg.sv
// rtl/iob_wishbone2iob_pkg.sv - shared state encoding and constants for the Wishbone-to-IOb bridge
package iob_wishbone2iob_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT_R = 3'd2,
    ST_ACK    = 3'd3,
    ST_ERR    = 3'd4,
    ST_DRAIN  = 3'd5
  } state_e;

  localparam int TIMEOUT_DEF = 256;

  function automatic int sel_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/iob_wishbone2iob_tmo_if.sv
// rtl/iob_wishbone2iob_tmo_if.sv - Wishbone slave side and IOb master side signal bundle
interface iob_wishbone2iob_tmo_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import iob_wishbone2iob_pkg::*;

  localparam int SEL_W = sel_w(DATA_W);

  logic [ADDR_W-1:0] wb_addr_i;
  logic [DATA_W-1:0] wb_data_i;
  logic [SEL_W-1:0]  wb_select_i;
  logic              wb_we_i;
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic [DATA_W-1:0] wb_data_o;
  logic              wb_ack_o;
  logic              wb_err_o;

  logic              iob_avalid_o;
  logic [ADDR_W-1:0] iob_address_o;
  logic [DATA_W-1:0] iob_wdata_o;
  logic [SEL_W-1:0]  iob_wstrb_o;
  logic              iob_rvalid_i;
  logic [DATA_W-1:0] iob_rdata_i;
  logic              iob_ready_i;

  modport slave (
    input  wb_addr_i, wb_data_i, wb_select_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_data_o, wb_ack_o, wb_err_o,
    output iob_avalid_o, iob_address_o, iob_wdata_o, iob_wstrb_o,
    input  iob_rvalid_i, iob_rdata_i, iob_ready_i
  );

  modport master (
    output wb_addr_i, wb_data_i, wb_select_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_data_o, wb_ack_o, wb_err_o,
    input  iob_avalid_o, iob_address_o, iob_wdata_o, iob_wstrb_o,
    output iob_rvalid_i, iob_rdata_i, iob_ready_i
  );

endinterface

// File: rtl/iob_wb2iob_tmo_cnt.sv
// rtl/iob_wb2iob_tmo_cnt.sv - per-phase timeout counter; expired is never raised when TIMEOUT is 0
module iob_wb2iob_tmo_cnt #(
  parameter int TMO_W   = 16,
  parameter int TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cke_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TMO_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + TMO_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)      cnt_q <= '0;
    else if (cke_i) cnt_q <= cnt_d;
  end

  assign expired_o = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/iob_wishbone2iob_tmo.sv
// rtl/iob_wishbone2iob_tmo.sv - Wishbone B4 classic slave to IOb master bridge with timeout error and abort drain
module iob_wishbone2iob_tmo
  import iob_wishbone2iob_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TMO_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cke_i,
  iob_wishbone2iob_tmo_if.slave bus,
  output logic                  busy_o
);

  localparam int SEL_W = sel_w(DATA_W);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [SEL_W-1:0]  wstrb_q;
  logic              avalid_q;
  logic              ack_q;
  logic              err_q;
  logic              busy_q;
  logic              is_wr;
  logic              cnt_stay;
  logic              expired;

  assign is_wr = |wstrb_q;

  // The counter keeps running only while a waiting state stays put; any exit clears it.
  always_comb begin
    cnt_stay = 1'b0;
    case (state_q)
      ST_REQ:    cnt_stay = !bus.iob_ready_i && !expired;
      ST_WAIT_R: cnt_stay = !bus.iob_rvalid_i && bus.wb_cyc_i && !expired;
      ST_DRAIN:  cnt_stay = !bus.iob_rvalid_i && !expired;
      default:   cnt_stay = 1'b0;
    endcase
  end

  iob_wb2iob_tmo_cnt #(
    .TMO_W  (TMO_W),
    .TIMEOUT(TIMEOUT)
  ) u_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cke_i    (cke_i),
    .clr_i    (!cnt_stay),
    .en_i     (cnt_stay),
    .expired_o(expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      avalid_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else if (cke_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (bus.wb_cyc_i && bus.wb_stb_i) begin
          addr_q   <= bus.wb_addr_i;
          wdata_q  <= bus.wb_data_i;
          wstrb_q  <= bus.wb_we_i ? bus.wb_select_i : '0;
          avalid_q <= 1'b1;
          busy_q   <= 1'b1;
          state_q  <= ST_REQ;
        end
        ST_REQ: if (bus.iob_ready_i) begin
          avalid_q <= 1'b0;
          if (!bus.wb_cyc_i) begin
            // An abandoned read still owes us a response that must be swallowed.
            state_q <= is_wr ? ST_IDLE : ST_DRAIN;
            busy_q  <= !is_wr;
          end else if (is_wr) begin
            ack_q   <= 1'b1;
            state_q <= ST_ACK;
          end else begin
            state_q <= ST_WAIT_R;
          end
        end else if (expired) begin
          avalid_q <= 1'b0;
          if (bus.wb_cyc_i) begin
            err_q   <= 1'b1;
            state_q <= ST_ERR;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT_R: if (bus.iob_rvalid_i) begin
          if (bus.wb_cyc_i) begin
            rdata_q <= bus.iob_rdata_i;
            ack_q   <= 1'b1;
            state_q <= ST_ACK;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end else if (!bus.wb_cyc_i) begin
          state_q <= ST_DRAIN;
        end else if (expired) begin
          err_q   <= 1'b1;
          state_q <= ST_ERR;
        end
        ST_ACK, ST_ERR: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_DRAIN: if (bus.iob_rvalid_i || expired) begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          avalid_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.wb_data_o     = rdata_q;
  assign bus.wb_ack_o      = ack_q;
  assign bus.wb_err_o      = err_q;
  assign bus.iob_avalid_o  = avalid_q;
  assign bus.iob_address_o = addr_q;
  assign bus.iob_wdata_o   = wdata_q;
  assign bus.iob_wstrb_o   = wstrb_q;
  assign busy_o            = busy_q;

endmodule

// File: tb/tb_iob_wishbone2iob_tmo.sv
// tb/tb_iob_wishbone2iob_tmo.sv - self-checking bench for the Wishbone-to-IOb timeout bridge (32- and 64-bit)
`timescale 1ns/1ps
module tb_iob_wishbone2iob_tmo;

  localparam int TMO = 8;

  typedef struct {
    bit          wide;
    bit          we;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [7:0]  sel;
    int          rw;
    int          vw;
    logic [63:0] rd;
    int          e_kind;
    int          e_cyc;
    int          e_av;
    logic [7:0]  e_wstrb;
    logic [63:0] e_data;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cke, use64;
  logic d_cyc, d_stb, d_we, d_ready, d_rvalid;
  logic [31:0] d_addr;
  logic [63:0] d_wdata, d_rdata;
  logic [7:0]  d_sel;
  logic busy32, busy64;

  iob_wishbone2iob_tmo_if #(.ADDR_W(32), .DATA_W(32)) b32();
  iob_wishbone2iob_tmo_if #(.ADDR_W(32), .DATA_W(64)) b64();

  iob_wishbone2iob_tmo #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .TMO_W(16)) u32 (
    .clk_i(clk), .rst_i(rst), .cke_i(cke), .bus(b32), .busy_o(busy32));
  iob_wishbone2iob_tmo #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TMO), .TMO_W(16)) u64 (
    .clk_i(clk), .rst_i(rst), .cke_i(cke), .bus(b64), .busy_o(busy64));

  assign b32.wb_addr_i    = d_addr;
  assign b32.wb_data_i    = d_wdata[31:0];
  assign b32.wb_select_i  = d_sel[3:0];
  assign b32.wb_we_i      = d_we;
  assign b32.wb_cyc_i     = d_cyc & ~use64;
  assign b32.wb_stb_i     = d_stb & ~use64;
  assign b32.iob_rvalid_i = d_rvalid & ~use64;
  assign b32.iob_rdata_i  = d_rdata[31:0];
  assign b32.iob_ready_i  = d_ready & ~use64;
  assign b64.wb_addr_i    = d_addr;
  assign b64.wb_data_i    = d_wdata;
  assign b64.wb_select_i  = d_sel;
  assign b64.wb_we_i      = d_we;
  assign b64.wb_cyc_i     = d_cyc & use64;
  assign b64.wb_stb_i     = d_stb & use64;
  assign b64.iob_rvalid_i = d_rvalid & use64;
  assign b64.iob_rdata_i  = d_rdata;
  assign b64.iob_ready_i  = d_ready & use64;

  logic o_avalid, o_ack, o_err, o_busy;
  logic [31:0] o_addr;
  logic [63:0] o_wdata, o_data;
  logic [7:0]  o_wstrb;
  assign o_avalid = use64 ? b64.iob_avalid_o  : b32.iob_avalid_o;
  assign o_ack    = use64 ? b64.wb_ack_o      : b32.wb_ack_o;
  assign o_err    = use64 ? b64.wb_err_o      : b32.wb_err_o;
  assign o_busy   = use64 ? busy64            : busy32;
  assign o_addr   = use64 ? b64.iob_address_o : b32.iob_address_o;
  assign o_wdata  = use64 ? b64.iob_wdata_o   : {32'h0, b32.iob_wdata_o};
  assign o_data   = use64 ? b64.wb_data_o     : {32'h0, b32.wb_data_o};
  assign o_wstrb  = use64 ? b64.iob_wstrb_o   : {4'h0, b32.iob_wstrb_o};

  int n_pass = 0;
  int n_total = 0;
  int both_hi = 0;

  int r_kind, r_cyc, r_av, r_nresp, r_idle;
  bit r_stable;
  logic [7:0]  r_wstrb;
  logic [31:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] last_d [2];

  always @(negedge clk)
    if ((b32.wb_ack_o && b32.wb_err_o) || (b64.wb_ack_o && b64.wb_err_o)) both_hi++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Outcome from the bridge rules: REQ and WAIT_R each get TMO cycles, ready/rvalid at the last one still wins.
  function automatic void model(input bit we, input int rw, input int vw,
                                output int kind, output int cyc, output int av);
    av = (rw < TMO) ? rw + 1 : TMO;
    if (rw >= TMO)     begin kind = 2; cyc = TMO + 1;      end
    else if (we)       begin kind = 1; cyc = rw + 2;       end
    else if (vw < TMO) begin kind = 1; cyc = rw + vw + 3;  end
    else               begin kind = 2; cyc = rw + TMO + 2; end
  endfunction

  task automatic run_txn(input vec_t v);
    int rv_at;
    use64 = v.wide; cke = 1'b1;
    d_cyc = 1; d_stb = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wd; d_sel = v.sel;
    d_ready = 0; d_rvalid = 0; d_rdata = 64'h0;
    rv_at = -1; r_kind = 0; r_cyc = -1; r_av = 0; r_nresp = 0; r_idle = -1; r_stable = 1;
    r_wstrb = 0; r_addr = 0; r_wdata = 0;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      d_ready = 0; d_rvalid = 0;
      if (o_ack || o_err) begin
        r_nresp++;
        if (r_kind == 0) begin r_kind = o_ack ? 1 : 2; r_cyc = c; end
        d_cyc = 0; d_stb = 0;
      end else if (r_kind != 0 && c > r_cyc && r_idle < 0 && !o_busy) begin
        r_idle = c;
      end
      if (o_avalid) begin
        if (r_av == 0) begin r_wstrb = o_wstrb; r_addr = o_addr; r_wdata = o_wdata; end
        else if (o_wstrb !== r_wstrb || o_addr !== r_addr || o_wdata !== r_wdata) r_stable = 0;
        r_av++;
        if (r_av == v.rw + 1) begin
          d_ready = 1;
          if (o_wstrb == 0) rv_at = c + 1 + v.vw;
        end
      end
      if (c == rv_at) begin d_rvalid = 1; d_rdata = v.rd; end
      if (r_kind != 0 && c >= r_cyc + 2 && c >= rv_at + 2) break;
    end
    d_cyc = 0; d_stb = 0; d_ready = 0; d_rvalid = 0;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    run_txn(v);
    chk($sformatf("%s.kind", tag),   64'(r_kind),  64'(v.e_kind));
    chk($sformatf("%s.cycle", tag),  64'(r_cyc),   64'(v.e_cyc));
    chk($sformatf("%s.avalid", tag), 64'(r_av),    64'(v.e_av));
    chk($sformatf("%s.wstrb", tag),  64'(r_wstrb), 64'(v.e_wstrb));
    chk($sformatf("%s.addr", tag),   64'(r_addr),  64'(v.addr));
    chk($sformatf("%s.wdata", tag),  r_wdata,      v.wd);
    chk($sformatf("%s.stable", tag), 64'(r_stable), 64'd1);
    chk($sformatf("%s.nresp", tag),  64'(r_nresp), 64'd1);
    chk($sformatf("%s.idle", tag),   64'(r_idle),  64'(v.e_cyc + 1));
    chk($sformatf("%s.data", tag),   o_data,       v.e_data);
  endtask

  // Read accepted, master leaves in WAIT_R; response comes dly cycles later or never.
  task automatic abort_seq(input int dly, input int exp_idle, input logic [63:0] exp_data, input string tag);
    int nresp, idle;
    logic busy_at_rv;
    use64 = 0; cke = 1;
    d_cyc = 1; d_stb = 1; d_we = 0; d_addr = 32'h50; d_sel = 8'hF; d_ready = 0; d_rvalid = 0;
    nresp = 0; idle = -1; busy_at_rv = 0;
    for (int c = 1; c < 25; c++) begin
      @(negedge clk);
      d_ready = 0; d_rvalid = 0;
      if (o_ack || o_err) nresp++;
      if (c == 1 && o_avalid) d_ready = 1;
      if (c == 2) begin d_cyc = 0; d_stb = 0; end
      if (c == 2 + dly) begin d_rvalid = 1; d_rdata = 64'h1234; busy_at_rv = o_busy; end
      if (c > 2 && idle < 0 && !o_busy) idle = c;
    end
    chk($sformatf("%s.nresp", tag), 64'(nresp), 64'd0);
    chk($sformatf("%s.idle", tag),  64'(idle),  64'(exp_idle));
    chk($sformatf("%s.data", tag),  o_data,     exp_data);
    if (dly < 20) chk($sformatf("%s.busy_at_rvalid", tag), 64'(busy_at_rv), 64'd1);
  endtask

  vec_t tbl [9];
  vec_t rv;

  initial begin
    rst = 1; cke = 1; use64 = 0;
    d_cyc = 0; d_stb = 0; d_we = 0; d_ready = 0; d_rvalid = 0;
    d_addr = 0; d_wdata = 0; d_rdata = 0; d_sel = 0;
    tbl[0] = '{0, 1, 32'h10, 64'hA5A55A5A, 8'h0F, 0,  0, 64'h0,        1, 2,  1, 8'h0F, 64'h0};
    tbl[1] = '{0, 0, 32'h20, 64'h0,        8'h0F, 3,  2, 64'hDEADBEEF, 1, 8,  4, 8'h00, 64'hDEADBEEF};
    tbl[2] = '{0, 0, 32'h24, 64'h0,        8'h0F, 20, 0, 64'h0,        2, 9,  8, 8'h00, 64'hDEADBEEF};
    tbl[3] = '{0, 0, 32'h28, 64'h0,        8'h0F, 0,  0, 64'h13579BDF, 1, 3,  1, 8'h00, 64'h13579BDF};
    tbl[4] = '{0, 0, 32'h2C, 64'h0,        8'h0F, 0,  7, 64'h0BADF00D, 1, 10, 1, 8'h00, 64'h0BADF00D};
    tbl[5] = '{0, 0, 32'h30, 64'h0,        8'h0F, 1,  8, 64'h11111111, 2, 11, 2, 8'h00, 64'h0BADF00D};
    tbl[6] = '{0, 1, 32'h34, 64'h12345678, 8'h05, 7,  0, 64'h0,        1, 9,  8, 8'h05, 64'h0BADF00D};
    tbl[7] = '{1, 1, 32'h40, 64'h0123456789ABCDEF, 8'h0F, 0, 0, 64'h0, 1, 2,  1, 8'h0F, 64'h0};
    tbl[8] = '{1, 0, 32'h48, 64'h0, 8'hFF, 2, 7, 64'hFEDCBA9876543210, 1, 12, 3, 8'h00, 64'hFEDCBA9876543210};

    repeat (3) @(negedge clk);
    chk("reset32", {b32.iob_avalid_o, b32.wb_ack_o, b32.wb_err_o, busy32, b32.iob_wstrb_o, b32.wb_data_o}, 64'h0);
    chk("reset64", {b64.iob_avalid_o, b64.wb_ack_o, b64.wb_err_o, busy64, b64.iob_wstrb_o, b64.wb_data_o[59:0]}, 64'h0);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

    abort_seq(5,   8,       64'h0BADF00D, "abort_rvalid");
    abort_seq(100, 3 + TMO, 64'h0BADF00D, "abort_drain_tmo");

    // cke low for four cycles in WAIT_R: rvalid during the freeze is missed and the timeout is postponed.
    begin
      int kind, cyc, nresp;
      logic busy_frz;
      use64 = 0; cke = 1;
      d_cyc = 1; d_stb = 1; d_we = 0; d_addr = 32'h70; d_sel = 8'hF;
      kind = 0; cyc = -1; nresp = 0; busy_frz = 0;
      for (int c = 1; c < 30; c++) begin
        @(negedge clk);
        d_ready = 0; d_rvalid = 0;
        if (o_ack || o_err) begin
          nresp++;
          if (kind == 0) begin kind = o_ack ? 1 : 2; cyc = c; end
          d_cyc = 0; d_stb = 0;
        end
        if (c == 1 && o_avalid) d_ready = 1;
        if (c == 2) cke = 0;
        if (c == 3) begin d_rvalid = 1; d_rdata = 64'h5555; end
        if (c == 5) busy_frz = o_busy;
        if (c == 6) cke = 1;
      end
      chk("cke.kind",  64'(kind),     64'd2);
      chk("cke.cycle", 64'(cyc),      64'(6 + TMO));
      chk("cke.nresp", 64'(nresp),    64'd1);
      chk("cke.busy",  64'(busy_frz), 64'd1);
      chk("cke.data",  o_data,        64'h0BADF00D);
    end

    // Reset while REQ waits on ready, with cke low: reset still wins.
    use64 = 0; cke = 1;
    d_cyc = 1; d_stb = 1; d_we = 1; d_addr = 32'h60; d_wdata = 64'h77; d_sel = 8'h3;
    repeat (3) @(negedge clk);
    chk("rst_req.avalid_before", 64'(o_avalid), 64'd1);
    rst = 1; cke = 0;
    @(negedge clk);
    chk("rst_req.outs", {o_avalid, o_ack, o_err, o_busy, o_wstrb, o_addr}, 64'h0);
    chk("rst_req.wdata", o_wdata, 64'h0);
    chk("rst_req.data",  o_data,  64'h0);
    rst = 0; cke = 1; d_cyc = 0; d_stb = 0;
    @(negedge clk);
    chk("rst_req.idle", {o_avalid, o_busy}, 64'h0);

    last_d[0] = 64'h0;
    last_d[1] = 64'h0;
    for (int i = 0; i < 30; i++) begin
      rv.wide = 1'($urandom_range(0, 1));
      rv.we   = 1'($urandom_range(0, 1));
      rv.addr = $urandom;
      rv.wd   = {$urandom, $urandom};
      rv.rd   = {$urandom, $urandom};
      if (!rv.wide) begin rv.wd[63:32] = 32'h0; rv.rd[63:32] = 32'h0; end
      rv.sel  = rv.wide ? 8'($urandom_range(1, 255)) : 8'($urandom_range(1, 15));
      rv.rw   = $urandom_range(0, 10);
      rv.vw   = $urandom_range(0, 10);
      model(rv.we, rv.rw, rv.vw, rv.e_kind, rv.e_cyc, rv.e_av);
      rv.e_wstrb = rv.we ? rv.sel : 8'h0;
      if (rv.e_kind == 1 && !rv.we) last_d[rv.wide] = rv.rd;
      rv.e_data = last_d[rv.wide];
      apply_vec(rv, $sformatf("rnd%0d", i));
    end

    chk("ack_err_exclusive", 64'(both_hi), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/iob_wishbone2iob_tmo.md
Name: iob_wishbone2iob_tmo

Overview:
Parametrised Wishbone (classic, B4) slave to IOb-bus master bridge, the successor to the fixed 32-bit bridge used in the UART16550 simulation wrappers.
- Adds generic DATA_W/ADDR_W.
- Adds a bus-error response (wb_err_o) driven by a programmable-length transaction timeout.
- Handles correct abort when the master drops wb_cyc_i mid-transfer, including draining an outstanding IOb read response.
- Sits between any Wishbone master (testbench, CPU) and an IOb peripheral.

Parameters:
ADDR_W, 32, address width of both buses (passed through unchanged)
DATA_W, 32, data width; multiple of 8 (8..64)
TIMEOUT, 256, cycles allowed per transaction phase before error; 0 disables the timeout
TMO_W, 16, timeout counter width; TIMEOUT must be < 2**TMO_W

Ports:
clk_i  in  1  clock, single clock domain
rst_i  in  1  reset, synchronous, active-high
cke_i  in  1  clock enable; when low, all state and outputs hold
wb_addr_i  in  ADDR_W  Wishbone address
wb_data_i  in  DATA_W  Wishbone write data
wb_select_i  in  DATA_W/8  byte select
wb_we_i  in  1  write enable
wb_cyc_i  in  1  cycle
wb_stb_i  in  1  strobe
wb_data_o  out  DATA_W  read data, registered
wb_ack_o  out  1  acknowledge, single-cycle pulse
wb_err_o  out  1  timeout error, single-cycle pulse
iob_avalid_o  out  1  IOb request valid
iob_address_o  out  ADDR_W  IOb address
iob_wdata_o  out  DATA_W  IOb write data
iob_wstrb_o  out  DATA_W/8  IOb write strobe; all-zero means read
iob_rvalid_i  in  1  IOb read data valid
iob_rdata_i  in  DATA_W  IOb read data
iob_ready_i  in  1  IOb request accepted
busy_o  out  1  high whenever state != IDLE

Behaviour:
- All outputs are registered.
- Reset (rst_i=1 at a clock edge, regardless of cke_i or state) forces IDLE.
  - All outputs go to 0, including wb_data_o; the timeout counter clears.
  - An IOb transaction in flight is abandoned.
- States: IDLE, REQ, WAIT_R, ACK, ERR, DRAIN.
- IDLE: when wb_cyc_i & wb_stb_i, latch the request and go to REQ next cycle.
  - Latch address, wdata, and wstrb = wb_we_i ? wb_select_i : 0.
  - Set iob_avalid_o=1.
- REQ: iob_avalid_o and request fields are held stable until iob_ready_i=1.
  - On ready: drop avalid. A write goes to ACK; a read goes to WAIT_R.
  - If wb_cyc_i=0 at ready: a write goes to IDLE and a read goes to DRAIN, with no ack.
- WAIT_R: iob_rvalid_i is sampled only from the cycle after ready.
  - On rvalid: capture iob_rdata_i into wb_data_o and go to ACK.
  - If wb_cyc_i drops: go to DRAIN.
- ACK: wb_ack_o=1 for exactly one cycle, then IDLE.
  - A new request is accepted in IDLE the following cycle.
  - Minimum latency with zero-wait IOb, stb at cycle 0: write ack at cycle 2; read ack at cycle 3 (ready c1, rvalid c2).
- ERR: wb_err_o=1 for one cycle, then IDLE. wb_data_o is unchanged.
- DRAIN: wait for iob_rvalid_i, discard the data (wb_data_o unchanged), go to IDLE. The timeout also applies here; on expiry go to IDLE silently.
- Timeout:
  - The counter clears on every state entry and increments each enabled cycle in REQ, WAIT_R and DRAIN.
  - When it reaches TIMEOUT-1 without the awaited event:
    - REQ: drop avalid, go to ERR (or IDLE if wb_cyc_i=0).
    - WAIT_R: go to ERR.
    - DRAIN: go to IDLE.
  - An awaited event in the same cycle as expiry wins.
  - With TIMEOUT=0 the counter never expires.
- iob_rvalid_i outside WAIT_R/DRAIN is ignored. Late responses after a timeout are dropped.
- wb_ack_o and wb_err_o are never both high.
- Ack and err are never issued when wb_cyc_i was low in the deciding cycle.
- Every outcome takes at least one cycle; a back-to-back stb with ack high is not a new request.

Decomposition:
- Package iob_wishbone2iob_pkg:
  - state encoding localparams (3-bit);
  - SEL_W = DATA_W/8 function;
  - default TIMEOUT constant.
- Sub-module iob_wb2iob_tmo_cnt:
  - parametrised TMO_W counter with clear/enable/cke inputs;
  - compares against TIMEOUT;
  - outputs expired, held at 0 when TIMEOUT=0.
- The FSM and datapath registers live in the top module.

Test Plan:
- Write, zero-wait: addr=0x10, data=0xA5A5_5A5A, sel=0xF, ready in first REQ cycle → iob_wstrb_o=0xF, avalid 1 cycle, wb_ack_o at cycle 2, busy_o low at cycle 3.
- Read with 3 ready-wait and 2 rvalid-wait cycles: rdata=0xDEAD_BEEF → avalid held stable 4 cycles, wstrb=0, wb_data_o=0xDEADBEEF with single-cycle ack.
- Timeout, TIMEOUT=8, ready never asserted → avalid drops after 8 REQ cycles, wb_err_o pulses once, no ack; then a good read completes normally.
- Abort: read accepted, wb_cyc_i dropped before rvalid, rvalid arrives 5 cycles later with 0x1234 → no ack/err, wb_data_o unchanged, busy_o low the cycle after rvalid.
- Reset mid-REQ and cke_i: cke_i low for 4 cycles during WAIT_R freezes the state and counter; rst_i pulsed during REQ → all outputs 0 next cycle, state IDLE.
- DATA_W=64, sel=0x0F write → iob_wstrb_o=0x0F; simultaneous rvalid and timeout expiry → ack wins, no err.
